sdrc_wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that lets N Wishbone masters share the single Wishbone slave port of sdrc_top.
- Holds a grant for a whole cycle, so bursts are never split.
- Blocks all access until sdr_init_done is high.
- Runs a per-grant ack watchdog that terminates a stalled transfer with an error and frees the port.

---
 rtl/sdrc_wb_arb_pkg.sv | 17 +
 rtl/sdrc_rr_pick.sv | 39 +++
 rtl/sdrc_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdrc_wb_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_wb_arb_pkg.sv
// Shared types and constants for the SDRAM controller Wishbone arbiter.
// Contents:
//   arb_state_e     - arbitration FSM state (idle / grant / drain)
//   WB_CTI_*        - Wishbone cycle type identifiers used by masters
package sdrc_wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin first-one finder.
// Scans req_i starting at position rr_i and moving upward with wrap-around;
// reports the first set position.
// Ports:
//   req_i   - request vector, one bit per requester
//   rr_i    - highest-priority position for this scan
//   idx_o   - index of the chosen requester (0 when none)
//   found_o - at least one request bit is set
module sdrc_rr_pick #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   rr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  logic [IdxW:0] pos;

  // Walk offsets from farthest to nearest so the nearest set bit is the
  // last one written and therefore wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      pos = {1'b0, rr_i} + (IdxW + 1)'(i);
      if (pos >= (IdxW + 1)'(NumReq)) begin
        pos = pos - (IdxW + 1)'(NumReq);
      end
      if (req_i[pos[IdxW-1:0]]) begin
        idx_o   = pos[IdxW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the sdrc_top slave port among NUM_M
// masters. A grant lasts for a whole Wishbone cycle (cyc high), so bursts are
// never split. No grant is issued before SDRAM init completes. A watchdog
// aborts a transfer that waits TIMEOUT cycles for ack and drains the owner.
// Ports:
//   wb_clk_i, wb_rst_i   - clock, synchronous active-high reset
//   sdr_init_done        - SDRAM init complete; gates new arbitration
//   m_*_i / m_*_o        - packed per-master Wishbone signals
//   m_dat_o              - read data broadcast, valid with own ack
//   s_*_o / s_*_i        - Wishbone master port towards sdrc_top
//   gnt_valid_o          - a master owns the port (grant or drain)
//   gnt_idx_o            - current / last owner index
module sdrc_wb_arbiter
  import sdrc_wb_arb_pkg::*;
#(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned AW      = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int unsigned SW     = DW / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  input  logic [NUM_M-1:0]  m_cyc_i,
  input  logic [NUM_M-1:0]  m_stb_i,
  input  logic [NUM_M-1:0]  m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  input  logic [NUM_M*SW-1:0] m_sel_i,
  input  logic [NUM_M*3-1:0]  m_cti_i,
  output logic [NUM_M-1:0]  m_ack_o,
  output logic [NUM_M-1:0]  m_err_o,
  output logic [DW-1:0]     m_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [SW-1:0]     s_sel_o,
  output logic [2:0]        s_cti_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_dat_i,
  output logic              gnt_valid_o,
  output logic [GW-1:0]     gnt_idx_o
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  gnt_q, gnt_d;
  logic [GW-1:0]  rr_q, rr_d;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

  logic [NUM_M-1:0] req;
  logic [GW-1:0]    pick_idx;
  logic             pick_found;
  logic             gnt_cyc;
  logic             stall;
  logic             wd_hit;
  logic [GW-1:0]    rr_next;

  assign req     = m_cyc_i & m_stb_i & {NUM_M{sdr_init_done}};
  assign gnt_cyc = m_cyc_i[gnt_q];
  assign stall   = (state_q == StGrant) && m_stb_i[gnt_q] && !s_ack_i;
  // Release by the master takes priority over an abort in the same cycle.
  assign wd_hit  = (TIMEOUT != 0) && stall && gnt_cyc && (wd_cnt_q == WdLast);
  assign rr_next = (gnt_q == GW'(NUM_M - 1)) ? '0 : gnt_q + 1'b1;

  sdrc_rr_pick #(
    .NumReq (NUM_M)
  ) u_pick (
    .req_i   (req),
    .rr_i    (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_q     <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    wd_cnt_d = '0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!gnt_cyc) begin
          state_d = StIdle;
          rr_d    = rr_next;
        end else if (wd_hit) begin
          state_d = StDrain;
        end else if (stall && (TIMEOUT != 0)) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (!gnt_cyc) begin
          state_d = StIdle;
          rr_d    = rr_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_addr_o    = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    s_cti_o     = '0;
    m_ack_o     = '0;
    m_err_o     = '0;
    gnt_valid_o = 1'b0;
    if (state_q != StIdle) begin
      gnt_valid_o = 1'b1;
      s_we_o      = m_we_i[gnt_q];
      s_addr_o    = m_addr_i[gnt_q*AW +: AW];
      s_dat_o     = m_dat_i[gnt_q*DW +: DW];
      s_sel_o     = m_sel_i[gnt_q*SW +: SW];
      s_cti_o     = m_cti_i[gnt_q*3 +: 3];
    end
    // In drain, cyc/stb stay low and any late ack is swallowed.
    if (state_q == StGrant) begin
      s_cyc_o        = m_cyc_i[gnt_q];
      s_stb_o        = m_stb_i[gnt_q];
      m_ack_o[gnt_q] = s_ack_i;
      m_err_o[gnt_q] = wd_hit;
    end
  end

  assign m_dat_o   = s_dat_i;
  assign gnt_idx_o = gnt_q;

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
module tb_sdrc_wb_arbiter;
  import sdrc_wb_arb_pkg::*;

  localparam int unsigned NUM_M   = 4;
  localparam int unsigned AW      = 26;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned SW      = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic [NUM_M-1:0]    m_cyc, m_stb, m_we;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_dat;
  logic [NUM_M*SW-1:0] m_sel;
  logic [NUM_M*3-1:0]  m_cti;
  logic [NUM_M-1:0]    m_ack_o, m_err_o;
  logic [DW-1:0]       m_dat_o;
  logic                s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]       s_addr_o;
  logic [DW-1:0]       s_dat_o;
  logic [SW-1:0]       s_sel_o;
  logic [2:0]          s_cti_o;
  logic                s_ack_i;
  logic [DW-1:0]       s_dat_i;
  logic                gnt_valid_o;
  logic [1:0]          gnt_idx_o;

  logic slave_en  = 1'b0;
  logic force_ack = 1'b0;
  logic [DW-1:0] mem [0:1023];
  logic          mem_wr [0:1023];
  logic [9:0]    sa;
  logic [NUM_M-1:0] prev_ack;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdrc_wb_arbiter #(
    .NUM_M   (NUM_M),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init_done),
    .m_cyc_i       (m_cyc),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_addr_i      (m_addr),
    .m_dat_i       (m_dat),
    .m_sel_i       (m_sel),
    .m_cti_i       (m_cti),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .m_dat_o       (m_dat_o),
    .s_cyc_o       (s_cyc_o),
    .s_stb_o       (s_stb_o),
    .s_we_o        (s_we_o),
    .s_addr_o      (s_addr_o),
    .s_dat_o       (s_dat_o),
    .s_sel_o       (s_sel_o),
    .s_cti_o       (s_cti_o),
    .s_ack_i       (s_ack_i),
    .s_dat_i       (s_dat_i),
    .gnt_valid_o   (gnt_valid_o),
    .gnt_idx_o     (gnt_idx_o)
  );

  // Slave model: zero-wait ack when enabled; unwritten words read as A000_0000|addr.
  assign sa      = s_addr_o[9:0];
  assign s_ack_i = (slave_en & s_cyc_o & s_stb_o) | force_ack;
  assign s_dat_i = mem_wr[sa] ? mem[sa] : (32'hA000_0000 | {22'd0, sa});

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_wr[i] <= 1'b0;
    end else if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
      mem[sa]    <= s_dat_o;
      mem_wr[sa] <= 1'b1;
    end
  end

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
  endtask

  task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                       input logic [2:0] cti);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_addr[k*AW +: AW] = addr;
    m_dat[k*DW +: DW]  = dat;
    m_sel[k*SW +: SW]  = 4'hF;
    m_cti[k*3 +: 3]    = cti;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0; idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_gnt: valid=%b idx=%0d, required valid=0 idx=0", gnt_valid_o, gnt_idx_o);
    end
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: cyc/stb/we=%b, required 000", {s_cyc_o, s_stb_o, s_we_o});
    end
    checks++;
    if (s_addr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0 || s_cti_o !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h dat=%h sel=%h cti=%b, required all 0",
               s_addr_o, s_dat_o, s_sel_o, s_cti_o);
    end
    checks++;
    if (m_ack_o !== 4'b0 || m_err_o !== 4'b0) begin
      errors++;
      $display("FAIL reset_ack: ack=%b err=%b, required 0000/0000", m_ack_o, m_err_o);
    end
  endtask

  task automatic test_init_gate();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b1, 26'h100, 32'h1111_0100, WB_CTI_CLASSIC);
    drive(1, 1'b1, 1'b1, 1'b1, 26'h200, 32'h2222_0200, WB_CTI_CLASSIC);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (s_cyc_o !== 1'b0 || gnt_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL init_gate cycle %0d: s_cyc=%b gnt_valid=%b, required 0/0",
                 c, s_cyc_o, gnt_valid_o);
      end
      @(negedge clk);
    end
    init_done = 1'b1;
    #1;
    checks++;
    if (s_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL init_same_cycle: s_stb=%b, required 0", s_stb_o);
    end
    @(negedge clk); #1;
    checks++;
    if (s_stb_o !== 1'b1 || gnt_idx_o !== 2'd0 || s_addr_o !== 26'h100) begin
      errors++;
      $display("FAIL init_first_grant: stb=%b idx=%0d addr=%h, required 1/0/100",
               s_stb_o, gnt_idx_o, s_addr_o);
    end
    idle_all();
  endtask

  task automatic test_round_robin();
    logic [NUM_M-1:0] exp_ack;
    logic             exp_gv;
    @(negedge clk);
    rst = 1'b1; idle_all(); slave_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; prev_ack = '0;
    // Each master issues a single write, idles one cycle after its ack, repeats.
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (prev_ack[k]) drive(k, 1'b0, 1'b0, 1'b1, 26'h100 * (k + 1), 32'h0, WB_CTI_CLASSIC);
        else drive(k, 1'b1, 1'b1, 1'b1, 26'h100 * (k + 1), 32'hC0DE_0000 + c, WB_CTI_CLASSIC);
      end
      #1;
      exp_gv  = (c % 3) != 0;
      exp_ack = 4'b0000;
      if (c % 3 == 1) exp_ack = ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0010;
      checks++;
      if (m_ack_o !== exp_ack) begin
        errors++;
        $display("FAIL rr_ack cycle %0d: ack=%b, required %b", c, m_ack_o, exp_ack);
      end
      checks++;
      if (gnt_valid_o !== exp_gv) begin
        errors++;
        $display("FAIL rr_gnt_valid cycle %0d: got %b, required %b", c, gnt_valid_o, exp_gv);
      end
      prev_ack = m_ack_o;
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic test_burst_hold();
    logic [DW-1:0] exp_dat;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, 26'h40, 32'h0, WB_CTI_INCR);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, 1'b1, 1'b0, 26'(64 + b), 32'h0, (b == 3) ? WB_CTI_EOB : WB_CTI_INCR);
      drive(0, 1'b1, 1'b1, 1'b1, 26'h100, 32'h0BAD_0100, WB_CTI_CLASSIC);
      #1;
      exp_dat = 32'hA000_0000 | 32'(64 + b);
      checks++;
      if (m_ack_o !== 4'b0010 || gnt_idx_o !== 2'd1) begin
        errors++;
        $display("FAIL burst_ack beat %0d: ack=%b idx=%0d, required 0010/1", b, m_ack_o, gnt_idx_o);
      end
      checks++;
      if (m_dat_o !== exp_dat) begin
        errors++;
        $display("FAIL burst_data beat %0d: got %h, required %h", b, m_dat_o, exp_dat);
      end
      @(negedge clk);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, WB_CTI_CLASSIC);
    #1;
    checks++;
    if (m_ack_o !== 4'b0000 || gnt_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL burst_release: ack=%b valid=%b, required 0000/1", m_ack_o, gnt_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL burst_dead_cycle: valid=%b, required 0", gnt_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_idx_o !== 2'd0 || s_stb_o !== 1'b1 || s_addr_o !== 26'h100 || m_ack_o !== 4'b0001) begin
      errors++;
      $display("FAIL burst_next_owner: idx=%0d stb=%b addr=%h ack=%b, required 0/1/100/0001",
               gnt_idx_o, s_stb_o, s_addr_o, m_ack_o);
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_watchdog();
    logic [NUM_M-1:0] exp_err;
    slave_en = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 26'h100, 32'h0, WB_CTI_CLASSIC);
    drive(1, 1'b1, 1'b1, 1'b0, 26'h200, 32'h0, WB_CTI_CLASSIC);
    @(negedge clk);
    for (int s = 1; s <= 16; s++) begin
      #1;
      exp_err = (s == 16) ? 4'b0010 : 4'b0000;
      checks++;
      if (m_err_o !== exp_err || s_stb_o !== 1'b1) begin
        errors++;
        $display("FAIL wd_stall %0d: err=%b stb=%b, required %b/1", s, m_err_o, s_stb_o, exp_err);
      end
      @(negedge clk);
    end
    force_ack = 1'b1;
    #1;
    checks++;
    if (m_err_o !== 4'b0 || {s_cyc_o, s_stb_o} !== 2'b00 || gnt_valid_o !== 1'b1
        || m_ack_o !== 4'b0) begin
      errors++;
      $display("FAIL wd_drain: err=%b cyc/stb=%b valid=%b ack=%b, required 0000/00/1/0000",
               m_err_o, {s_cyc_o, s_stb_o}, gnt_valid_o, m_ack_o);
    end
    @(negedge clk);
    force_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, WB_CTI_CLASSIC);
    #1;
    checks++;
    if (gnt_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL wd_drain_hold: valid=%b, required 1", gnt_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wd_dead_cycle: valid=%b, required 0", gnt_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd0 || s_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL wd_next_owner: valid=%b idx=%0d stb=%b, required 1/0/1",
               gnt_valid_o, gnt_idx_o, s_stb_o);
    end
    @(negedge clk);
    idle_all();
    slave_en = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 26'h80, 32'hB000_0000, WB_CTI_INCR);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      drive(1, 1'b1, 1'b1, 1'b1, 26'(128 + b), 32'hB000_0000 + b, WB_CTI_INCR);
      #1;
      checks++;
      if (m_ack_o !== 4'b0010) begin
        errors++;
        $display("FAIL rst_burst_beat %0d: ack=%b, required 0010", b, m_ack_o);
      end
      @(negedge clk);
    end
    drive(1, 1'b1, 1'b1, 1'b1, 26'h82, 32'hB000_0002, WB_CTI_INCR);
    rst = 1'b1;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 26'h83, 32'hB000_0003, WB_CTI_EOB);
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000 || s_addr_o !== '0 || s_dat_o !== '0
        || s_sel_o !== '0 || s_cti_o !== '0) begin
      errors++;
      $display("FAIL rst_mid_bus: cyc/stb/we=%b addr=%h dat=%h sel=%h cti=%b, required all 0",
               {s_cyc_o, s_stb_o, s_we_o}, s_addr_o, s_dat_o, s_sel_o, s_cti_o);
    end
    checks++;
    if (m_ack_o !== 4'b0 || m_err_o !== 4'b0 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_gnt: ack=%b err=%b valid=%b idx=%0d, required 0/0/0/0",
               m_ack_o, m_err_o, gnt_valid_o, gnt_idx_o);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b1, 26'h100, 32'h0000_5A5A, WB_CTI_CLASSIC);
    drive(1, 1'b1, 1'b1, 1'b1, 26'h80, 32'hB000_0000, WB_CTI_INCR);
    #1;
    checks++;
    if (gnt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_idle: valid=%b, required 0", gnt_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd0 || s_addr_o !== 26'h100) begin
      errors++;
      $display("FAIL rst_release_winner: valid=%b idx=%0d addr=%h, required 1/0/100",
               gnt_valid_o, gnt_idx_o, s_addr_o);
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_data_routing();
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 1'b1, 26'h123, 32'hDEAD_BEEF, WB_CTI_CLASSIC);
    #1;
    checks++;
    if (m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL route_idle_ack: ack=%b, required 0000", m_ack_o);
    end
    @(negedge clk); #1;
    checks++;
    if (m_ack_o !== 4'b0100 || s_dat_o !== 32'hDEAD_BEEF || s_addr_o !== 26'h123
        || s_we_o !== 1'b1 || s_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL route_write: ack=%b dat=%h addr=%h we=%b sel=%h, required 0100/deadbeef/123/1/f",
               m_ack_o, s_dat_o, s_addr_o, s_we_o, s_sel_o);
    end
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, WB_CTI_CLASSIC);
    #1;
    checks++;
    if (m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL route_release_ack: ack=%b, required 0000", m_ack_o);
    end
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 1'b0, 26'h123, 32'h0, WB_CTI_CLASSIC);
    #1;
    checks++;
    if (m_ack_o !== 4'b0000 || gnt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL route_dead_cycle: ack=%b valid=%b, required 0000/0", m_ack_o, gnt_valid_o);
    end
    @(negedge clk); #1;
    checks++;
    if (m_ack_o !== 4'b1000 || m_dat_o !== 32'hDEAD_BEEF || gnt_idx_o !== 2'd3) begin
      errors++;
      $display("FAIL route_read: ack=%b dat=%h idx=%0d, required 1000/deadbeef/3",
               m_ack_o, m_dat_o, gnt_idx_o);
    end
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, WB_CTI_CLASSIC);
    #1;
    checks++;
    if (m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL route_end_ack: ack=%b, required 0000", m_ack_o);
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    idle_all();
    prev_ack = '0;
    test_reset();
    test_init_gate();
    test_round_robin();
    test_burst_hold();
    test_watchdog();
    test_reset_mid_burst();
    test_data_routing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
